ps2_frame_rx: RTL

Parametrised PS/2 device-to-host frame receiver: the next generation of the keyboard bit receiver. It synchronises and glitch-filters the raw `kbd_clk`/`kbd_dat` lines and samples on filtered falling clock edges. It checks start, parity (selectable mode) and stop bits, aborts stalled frames on a watchdog timeout, and buffers good bytes in a small FWFT FIFO with a valid/ready output handshake. It sits between the keyboard pins and the scan-code decoder.

---
 rtl/ps2_frame_rx.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: synchronised, glitch-filtered line sampling,
// start/parity/stop checks, an in-frame watchdog and a small FWFT output FIFO.
module ps2_frame_rx #(
  parameter int DATA_BITS      = 8,
  parameter int PARITY_MODE    = 1,
  parameter int FIFO_DEPTH     = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          kbd_clk,
  input  logic                          kbd_dat,
  output logic [DATA_BITS-1:0]          dout,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          timeout_err,
  output logic                          overflow
);

  localparam int HAS_PAR   = (PARITY_MODE != 0) ? 1 : 0;
  localparam int FRAME_LEN = DATA_BITS + HAS_PAR + 2;
  localparam int SR_W      = FRAME_LEN - 1;
  localparam int BC_W      = $clog2(FRAME_LEN + 1);
  localparam int WD_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = PTR_W + 1;

  localparam logic [BC_W-1:0]  LAST_BIT    = BC_W'(FRAME_LEN);
  localparam logic [WD_W-1:0]  WD_LIMIT    = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       FILT_LIMIT  = 4'(FILTER_LEN - 1);
  localparam logic [CNT_W-1:0] FULL_COUNT  = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RECV  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
  logic                   clk_s, dat_s;
  logic                   fclk_q, fclk_d, fclk_prev_q, fclk_prev_d, fall_q, fall_d;
  logic [3:0]             filt_cnt_q, filt_cnt_d;
  logic [1:0]             state_q, state_d;
  logic [BC_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [SR_W-1:0]        sr_q, sr_d;
  logic [WD_W-1:0]        wd_q, wd_d;
  logic [DATA_BITS-1:0]   data_w;
  logic                   stop_bit, par_bit, par_ok, push, push_ok, pop, full;
  logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;

  assign clk_s = clk_sync_q[SYNC_STAGES-1];
  assign dat_s = dat_sync_q[SYNC_STAGES-1];

  // fclk only follows the line after FILTER_LEN consecutive differing samples
  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], kbd_clk};
    dat_sync_d  = {dat_sync_q[SYNC_STAGES-2:0], kbd_dat};
    fclk_d      = fclk_q;
    filt_cnt_d  = '0;
    if (clk_s != fclk_q) begin
      if (filt_cnt_q == FILT_LIMIT) fclk_d = clk_s;
      else                          filt_cnt_d = filt_cnt_q + 4'd1;
    end
    fclk_prev_d = fclk_q;
    fall_d      = fclk_prev_q & ~fclk_q;
  end

  assign stop_bit = sr_q[SR_W-1];
  assign par_bit  = sr_q[DATA_BITS];
  assign data_w   = sr_q[DATA_BITS-1:0];

  always_comb begin
    case (PARITY_MODE)
      1:       par_ok = (^{data_w, par_bit}) == 1'b1;
      2:       par_ok = (^{data_w, par_bit}) == 1'b0;
      default: par_ok = 1'b1;
    endcase
  end

  // Bits shift in at the MSB so the frame ends up as {stop, parity, data}
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    sr_d        = sr_q;
    wd_d        = '0;
    timeout_err = 1'b0;
    frame_err   = 1'b0;
    parity_err  = 1'b0;
    push        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fall_q && !dat_s) begin
          bit_cnt_d = BC_W'(1);
          state_d   = S_RECV;
        end
      end
      S_RECV: begin
        if (fall_q) begin
          sr_d      = {dat_s, sr_q[SR_W-1:1]};
          bit_cnt_d = bit_cnt_q + BC_W'(1);
          if (bit_cnt_d == LAST_BIT) state_d = S_CHECK;
        end else if (wd_q == WD_LIMIT) begin
          timeout_err = 1'b1;
          bit_cnt_d   = '0;
          state_d     = S_IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_CHECK: begin
        bit_cnt_d = '0;
        state_d   = S_IDLE;
        if (!stop_bit)    frame_err  = 1'b1;
        else if (!par_ok) parity_err = 1'b1;
        else              push       = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy       = (state_q != S_IDLE);
  assign dout_valid = (count_q != '0);
  assign fifo_count = count_q;
  assign full       = (count_q == FULL_COUNT);
  assign pop        = dout_valid && dout_ready;
  assign push_ok    = push && (!full || pop);
  assign overflow   = push && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_ok && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push_ok && pop) count_d = count_q - CNT_W'(1);
    dout = '0;
    if (dout_valid) dout = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q  <= '1;
      dat_sync_q  <= '1;
      fclk_q      <= 1'b1;
      fclk_prev_q <= 1'b1;
      fall_q      <= 1'b0;
      filt_cnt_q  <= '0;
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      sr_q        <= '0;
      wd_q        <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      dat_sync_q  <= dat_sync_d;
      fclk_q      <= fclk_d;
      fclk_prev_q <= fclk_prev_d;
      fall_q      <= fall_d;
      filt_cnt_q  <= filt_cnt_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      sr_q        <= sr_d;
      wd_q        <= wd_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_w;
  end

endmodule
